alu_reservation_station: RTL and testbench

//   Holds dispatched ALU-class instructions (OP, OP-IMM, BRANCH, JAL, JALR, AUIPC) until both

---
 rtl/alu_reservation_station.sv | 182 ++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station: holds dispatched ops, snoops two CDBs, issues one ready op per cycle.
module alu_reservation_station #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _rs_valid,
  input  logic [ROB_W-1:0] _rs_rob_id,
  input  logic [6:0]       _rs_type,
  input  logic [3:0]       _rs_op,
  input  logic             _rs_q1_busy,
  input  logic [ROB_W-1:0] _rs_q1,
  input  logic [31:0]      _rs_v1,
  input  logic             _rs_q2_busy,
  input  logic [ROB_W-1:0] _rs_q2,
  input  logic [31:0]      _rs_v2,
  output logic             _rs_full,
  input  logic             _cdb_ready,
  input  logic [ROB_W-1:0] _cdb_rob_id,
  input  logic [31:0]      _cdb_value,
  input  logic             _lsb_cdb_ready,
  input  logic [ROB_W-1:0] _lsb_cdb_rob_id,
  input  logic [31:0]      _lsb_cdb_value,
  output logic             _alu_ready,
  output logic [ROB_W-1:0] _alu_rob_id,
  output logic [6:0]       _alu_type,
  output logic [3:0]       _alu_op,
  output logic [31:0]      _alu_v1,
  output logic [31:0]      _alu_v2
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] q1_busy_q, q1_busy_d, q2_busy_q, q2_busy_d;
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [ROB_W-1:0] rob_d [DEPTH];
  logic [ROB_W-1:0] q1_q [DEPTH];
  logic [ROB_W-1:0] q1_d [DEPTH];
  logic [ROB_W-1:0] q2_q [DEPTH];
  logic [ROB_W-1:0] q2_d [DEPTH];
  logic [6:0]       type_q [DEPTH];
  logic [6:0]       type_d [DEPTH];
  logic [3:0]       op_q [DEPTH];
  logic [3:0]       op_d [DEPTH];
  logic [31:0]      v1_q [DEPTH];
  logic [31:0]      v1_d [DEPTH];
  logic [31:0]      v2_q [DEPTH];
  logic [31:0]      v2_d [DEPTH];

  logic             alu_ready_q, alu_ready_d;
  logic [ROB_W-1:0] alu_rob_id_q, alu_rob_id_d;
  logic [6:0]       alu_type_q, alu_type_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [31:0]      alu_v1_q, alu_v1_d, alu_v2_q, alu_v2_d;

  logic             iss_found, free_found;
  logic [IDX_W-1:0] iss_idx, free_idx;

  // Returns {still_busy, value}; ALU CDB takes priority over LSB CDB.
  function automatic logic [32:0] capture(input logic busy, input logic [ROB_W-1:0] tag,
                                          input logic [31:0] value);
    if (!busy)                                      capture = {1'b0, value};
    else if (_cdb_ready && _cdb_rob_id == tag)      capture = {1'b0, _cdb_value};
    else if (_lsb_cdb_ready && _lsb_cdb_rob_id == tag) capture = {1'b0, _lsb_cdb_value};
    else                                            capture = {1'b1, value};
  endfunction

  assign _rs_full = &valid_q;

  always_comb begin
    valid_d      = valid_q;
    q1_busy_d    = q1_busy_q;
    q2_busy_d    = q2_busy_q;
    rob_d        = rob_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    type_d       = type_q;
    op_d         = op_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    alu_ready_d  = alu_ready_q;
    alu_rob_id_d = alu_rob_id_q;
    alu_type_d   = alu_type_q;
    alu_op_d     = alu_op_q;
    alu_v1_d     = alu_v1_q;
    alu_v2_d     = alu_v2_q;
    iss_found    = 1'b0;
    iss_idx      = '0;
    free_found   = 1'b0;
    free_idx     = '0;

    // Issue and allocation both look at pre-edge state only.
    for (int i = 0; i < DEPTH; i++) begin
      if (!iss_found && valid_q[i] && !q1_busy_q[i] && !q2_busy_q[i]) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    if (rdy_in) begin
      if (_clear) begin
        valid_d     = '0;
        alu_ready_d = 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i]) begin
            {q1_busy_d[i], v1_d[i]} = capture(q1_busy_q[i], q1_q[i], v1_q[i]);
            {q2_busy_d[i], v2_d[i]} = capture(q2_busy_q[i], q2_q[i], v2_q[i]);
          end
        end

        alu_ready_d = iss_found;
        if (iss_found) begin
          alu_rob_id_d     = rob_q[iss_idx];
          alu_type_d       = type_q[iss_idx];
          alu_op_d         = op_q[iss_idx];
          alu_v1_d         = v1_q[iss_idx];
          alu_v2_d         = v2_q[iss_idx];
          valid_d[iss_idx] = 1'b0;
        end

        if (_rs_valid && !_rs_full) begin
          valid_d[free_idx] = 1'b1;
          rob_d[free_idx]   = _rs_rob_id;
          type_d[free_idx]  = _rs_type;
          op_d[free_idx]    = _rs_op;
          q1_d[free_idx]    = _rs_q1;
          q2_d[free_idx]    = _rs_q2;
          {q1_busy_d[free_idx], v1_d[free_idx]} = capture(_rs_q1_busy, _rs_q1, _rs_v1);
          {q2_busy_d[free_idx], v2_d[free_idx]} = capture(_rs_q2_busy, _rs_q2, _rs_v2);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q      <= '0;
      alu_ready_q  <= 1'b0;
      alu_rob_id_q <= '0;
      alu_type_q   <= '0;
      alu_op_q     <= '0;
      alu_v1_q     <= '0;
      alu_v2_q     <= '0;
    end else begin
      valid_q      <= valid_d;
      alu_ready_q  <= alu_ready_d;
      alu_rob_id_q <= alu_rob_id_d;
      alu_type_q   <= alu_type_d;
      alu_op_q     <= alu_op_d;
      alu_v1_q     <= alu_v1_d;
      alu_v2_q     <= alu_v2_d;
    end
  end

  // Entry payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_in) begin
    q1_busy_q <= q1_busy_d;
    q2_busy_q <= q2_busy_d;
    rob_q     <= rob_d;
    q1_q      <= q1_d;
    q2_q      <= q2_d;
    type_q    <= type_d;
    op_q      <= op_d;
    v1_q      <= v1_d;
    v2_q      <= v2_d;
  end

  assign _alu_ready  = alu_ready_q;
  assign _alu_rob_id = alu_rob_id_q;
  assign _alu_type   = alu_type_q;
  assign _alu_op     = alu_op_q;
  assign _alu_v1     = alu_v1_q;
  assign _alu_v2     = alu_v2_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        clear;
  logic        rs_valid;
  logic [4:0]  rs_rob_id;
  logic [6:0]  rs_type;
  logic [3:0]  rs_op;
  logic        rs_q1_busy;
  logic [4:0]  rs_q1;
  logic [31:0] rs_v1;
  logic        rs_q2_busy;
  logic [4:0]  rs_q2;
  logic [31:0] rs_v2;
  logic        rs_full;
  logic        cdb_ready;
  logic [4:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic        lsb_ready;
  logic [4:0]  lsb_rob_id;
  logic [31:0] lsb_value;
  logic        alu_ready;
  logic [4:0]  alu_rob_id;
  logic [6:0]  alu_type;
  logic [3:0]  alu_op;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;

  int n_checks = 0;
  int n_fails  = 0;

  alu_reservation_station #(.DEPTH(8), .ROB_W(5)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), ._clear(clear),
    ._rs_valid(rs_valid), ._rs_rob_id(rs_rob_id), ._rs_type(rs_type), ._rs_op(rs_op),
    ._rs_q1_busy(rs_q1_busy), ._rs_q1(rs_q1), ._rs_v1(rs_v1),
    ._rs_q2_busy(rs_q2_busy), ._rs_q2(rs_q2), ._rs_v2(rs_v2), ._rs_full(rs_full),
    ._cdb_ready(cdb_ready), ._cdb_rob_id(cdb_rob_id), ._cdb_value(cdb_value),
    ._lsb_cdb_ready(lsb_ready), ._lsb_cdb_rob_id(lsb_rob_id), ._lsb_cdb_value(lsb_value),
    ._alu_ready(alu_ready), ._alu_rob_id(alu_rob_id), ._alu_type(alu_type), ._alu_op(alu_op),
    ._alu_v1(alu_v1), ._alu_v2(alu_v2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input logic [4:0] rob, input logic b1, input logic [4:0] q1, input logic [31:0] v1,
                      input logic b2, input logic [4:0] q2, input logic [31:0] v2);
    rs_valid = 1'b1; rs_rob_id = rob; rs_type = 7'h33; rs_op = 4'h0;
    rs_q1_busy = b1; rs_q1 = q1; rs_v1 = v1;
    rs_q2_busy = b2; rs_q2 = q2; rs_v2 = v2;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; rs_valid = 1'b0;
    rs_rob_id = '0; rs_type = '0; rs_op = '0; rs_q1_busy = 1'b0; rs_q1 = '0; rs_v1 = '0;
    rs_q2_busy = 1'b0; rs_q2 = '0; rs_v2 = '0;
    cdb_ready = 1'b0; cdb_rob_id = '0; cdb_value = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    tick(); tick();
    check("reset_ready", 32'(alu_ready), 32'd0);
    check("reset_full", 32'(rs_full), 32'd0);
    check("reset_v1", alu_v1, 32'd0);
    rst_n = 1'b1;
    tick();

    // Ready-at-dispatch op issues one edge after dispatch.
    disp(5'd3, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7);
    tick(); rs_valid = 1'b0;
    check("add_dispatch_edge_ready", 32'(alu_ready), 32'd0);
    tick();
    check("add_ready", 32'(alu_ready), 32'd1);
    check("add_rob", 32'(alu_rob_id), 32'd3);
    check("add_type", 32'(alu_type), 32'h33);
    check("add_v1", alu_v1, 32'd5);
    check("add_v2", alu_v2, 32'd7);
    tick();
    check("add_ready_drop", 32'(alu_ready), 32'd0);
    check("add_v1_hold", alu_v1, 32'd5);

    // ALU CDB wakeup, no same-edge bypass.
    disp(5'd10, 1'b1, 5'd9, 32'd0, 1'b0, 5'd0, 32'd2);
    tick(); rs_valid = 1'b0;
    tick();
    check("wake_pre_ready", 32'(alu_ready), 32'd0);
    cdb_ready = 1'b1; cdb_rob_id = 5'd9; cdb_value = 32'h1234;
    tick(); cdb_ready = 1'b0;
    check("wake_no_bypass", 32'(alu_ready), 32'd0);
    tick();
    check("wake_ready", 32'(alu_ready), 32'd1);
    check("wake_rob", 32'(alu_rob_id), 32'd10);
    check("wake_v1", alu_v1, 32'h1234);
    check("wake_v2", alu_v2, 32'd2);
    tick();

    // Dispatch-time forwarding from the LSB CDB.
    disp(5'd11, 1'b0, 5'd0, 32'd1, 1'b1, 5'd4, 32'd0);
    lsb_ready = 1'b1; lsb_rob_id = 5'd4; lsb_value = 32'hFF;
    tick(); rs_valid = 1'b0; lsb_ready = 1'b0;
    tick();
    check("fwd_ready", 32'(alu_ready), 32'd1);
    check("fwd_rob", 32'(alu_rob_id), 32'd11);
    check("fwd_v2", alu_v2, 32'hFF);
    tick();

    // Fill all entries with unready ops; overflow dispatch is dropped.
    for (int i = 0; i < 8; i++) begin
      disp(5'(i), 1'b1, 5'(16 + i), 32'd0, 1'b0, 5'd0, 32'(i));
      tick();
    end
    check("fill_full", 32'(rs_full), 32'd1);
    disp(5'd30, 1'b0, 5'd0, 32'd9, 1'b0, 5'd0, 32'd9);
    tick(); rs_valid = 1'b0;
    check("overflow_no_issue", 32'(alu_ready), 32'd0);
    check("overflow_full", 32'(rs_full), 32'd1);
    cdb_ready = 1'b1; cdb_rob_id = 5'd18; cdb_value = 32'hAA;
    lsb_ready = 1'b1; lsb_rob_id = 5'd21; lsb_value = 32'hBB;
    tick(); cdb_ready = 1'b0; lsb_ready = 1'b0;
    check("dual_wake_no_bypass", 32'(alu_ready), 32'd0);
    tick();
    check("dual_first_ready", 32'(alu_ready), 32'd1);
    check("dual_first_rob", 32'(alu_rob_id), 32'd2);
    check("dual_first_v1", alu_v1, 32'hAA);
    check("dual_first_v2", alu_v2, 32'd2);
    check("dual_full_freed", 32'(rs_full), 32'd0);
    tick();
    check("dual_second_ready", 32'(alu_ready), 32'd1);
    check("dual_second_rob", 32'(alu_rob_id), 32'd5);
    check("dual_second_v1", alu_v1, 32'hBB);
    tick();
    check("dual_then_idle", 32'(alu_ready), 32'd0);

    // Flush with two ready and two pending entries.
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_empty_full", 32'(rs_full), 32'd0);
    disp(5'd12, 1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0); tick();
    disp(5'd13, 1'b1, 5'd2, 32'd0, 1'b0, 5'd0, 32'd0); tick();
    disp(5'd14, 1'b1, 5'd3, 32'd0, 1'b0, 5'd0, 32'd0); tick();
    disp(5'd15, 1'b1, 5'd6, 32'd0, 1'b0, 5'd0, 32'd0); tick();
    rs_valid = 1'b0;
    cdb_ready = 1'b1; cdb_rob_id = 5'd1; cdb_value = 32'h11;
    lsb_ready = 1'b1; lsb_rob_id = 5'd2; lsb_value = 32'h22;
    tick(); cdb_ready = 1'b0; lsb_ready = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_ready", 32'(alu_ready), 32'd0);
    check("clear_full", 32'(rs_full), 32'd0);
    cdb_ready = 1'b1; cdb_rob_id = 5'd3; cdb_value = 32'h33;
    tick(); cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clear_no_issue", 32'(alu_ready), 32'd0);
    end

    // rdy low freezes pending issue and a held-high strobe.
    disp(5'd17, 1'b0, 5'd0, 32'h11, 1'b0, 5'd0, 32'h12);
    tick(); rs_valid = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_no_issue", 32'(alu_ready), 32'd0);
    end
    rdy = 1'b1; tick();
    check("unfreeze_ready", 32'(alu_ready), 32'd1);
    check("unfreeze_rob", 32'(alu_rob_id), 32'd17);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("freeze_hold_ready", 32'(alu_ready), 32'd1);
    end
    rdy = 1'b1; tick();
    check("after_freeze_ready", 32'(alu_ready), 32'd0);

    // Asynchronous reset mid-operation with three pending entries.
    disp(5'd20, 1'b1, 5'd24, 32'd0, 1'b0, 5'd0, 32'd0); tick();
    disp(5'd21, 1'b1, 5'd25, 32'd0, 1'b0, 5'd0, 32'd0); tick();
    disp(5'd22, 1'b1, 5'd26, 32'd0, 1'b0, 5'd0, 32'd0); tick();
    disp(5'd23, 1'b0, 5'd0, 32'h77, 1'b0, 5'd0, 32'h78); tick();
    rs_valid = 1'b0; tick();
    check("pre_reset_ready", 32'(alu_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ready", 32'(alu_ready), 32'd0);
    check("async_reset_full", 32'(rs_full), 32'd0);
    check("async_reset_rob", 32'(alu_rob_id), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cdb_ready = 1'b1; cdb_rob_id = 5'd24; lsb_ready = 1'b1; lsb_rob_id = 5'd25;
    tick(); cdb_rob_id = 5'd26; lsb_ready = 1'b0;
    tick(); cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_no_issue", 32'(alu_ready), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
